// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, depths and control-field encodings.
// DP_IO_PORT_EN (when defined) maps IO_ADDR onto an external I/O byte in datapath.
package cpu_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned RF_DEPTH    = 16;
  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DEPTH  = 256;

  localparam logic [DMEM_ADDR_W-1:0] IO_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_IMM  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/cpu_regfile.sv
// 16x8 register file: one synchronous write port, two gated combinational read ports.
// Registers clear asynchronously on rst; reads during a write return the old value.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]    w_data,
  input  logic                 w_wr,
  input  logic [RF_ADDR_W-1:0] rp_addr,
  input  logic                 rp_rd,
  output logic [DATA_W-1:0]    rp_data_c,
  input  logic [RF_ADDR_W-1:0] rq_addr,
  input  logic                 rq_rd,
  output logic [DATA_W-1:0]    rq_data_c
);

  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [DATA_W-1:0] rf_d [RF_DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < RF_DEPTH; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (w_wr) begin
      rf_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Disabled read ports drive zero so downstream ALU/store see a clean 0.
  assign rp_data_c = rp_rd ? rf_q[rp_addr] : '0;
  assign rq_data_c = rq_rd ? rf_q[rq_addr] : '0;

endmodule

// File: rtl/datapath.sv
// Execution datapath: register file, 4-function ALU, writeback mux and 256x8 data memory.
// Optional DP_IO_PORT_EN redirects loads/stores at IO_ADDR to io_in/io_out.
module datapath
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D_addr,
  input  logic       D_rd,
  input  logic       D_wr,
  input  logic [7:0] RF_W_data,
  input  logic       RF_s1,
  input  logic       RF_s0,
  input  logic [3:0] RF_W_addr,
  input  logic       RF_W_wr,
  input  logic [3:0] RF_Rp_addr,
  input  logic       RF_Rp_rd,
  input  logic [3:0] RF_Rq_addr,
  input  logic       RF_Rq_rd,
  input  logic       alu_s1,
  input  logic       alu_s0,
  output logic       RF_Rp_zero
`ifdef DP_IO_PORT_EN
  ,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
`endif
);

  logic [DATA_W-1:0] rp_data_c;
  logic [DATA_W-1:0] rq_data_c;
  logic [DATA_W-1:0] alu_res_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [DATA_W-1:0] wb_data_c;
  logic              dmem_we_c;
  logic [DATA_W-1:0] dmem_d;
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  alu_op_t           alu_op;
  wb_sel_t           wb_sel;

  assign alu_op = alu_op_t'({alu_s1, alu_s0});
  assign wb_sel = wb_sel_t'({RF_s1, RF_s0});

  cpu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .w_addr    (RF_W_addr),
    .w_data    (wb_data_c),
    .w_wr      (RF_W_wr),
    .rp_addr   (RF_Rp_addr),
    .rp_rd     (RF_Rp_rd),
    .rp_data_c (rp_data_c),
    .rq_addr   (RF_Rq_addr),
    .rq_rd     (RF_Rq_rd),
    .rq_data_c (rq_data_c)
  );

  // Modulo-2^8 arithmetic; carry and borrow are dropped.
  always_comb begin
    alu_res_c = rp_data_c;
    case (alu_op)
      ALU_PASS: alu_res_c = rp_data_c;
      ALU_ADD:  alu_res_c = DATA_W'(rp_data_c + rq_data_c);
      ALU_SUB:  alu_res_c = DATA_W'(rp_data_c - rq_data_c);
      ALU_AND:  alu_res_c = rp_data_c & rq_data_c;
      default:  alu_res_c = rp_data_c;
    endcase
  end

  always_comb begin
    wb_data_c = '0;
    case (wb_sel)
      WB_ALU:  wb_data_c = alu_res_c;
      WB_MEM:  wb_data_c = mem_rdata_c;
      WB_IMM:  wb_data_c = RF_W_data;
      WB_ZERO: wb_data_c = '0;
      default: wb_data_c = '0;
    endcase
  end

  assign dmem_d = rp_data_c;

`ifdef DP_IO_PORT_EN
  logic [DATA_W-1:0] io_out_q;
  logic [DATA_W-1:0] io_out_d;

  always_comb begin
    dmem_we_c   = D_wr && (D_addr != IO_ADDR);
    io_out_d    = io_out_q;
    mem_rdata_c = '0;
    if (D_wr && (D_addr == IO_ADDR)) begin
      io_out_d = rp_data_c;
    end
    if (D_rd) begin
      mem_rdata_c = (D_addr == IO_ADDR) ? io_in : dmem_q[D_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out_q <= '0;
    end else begin
      io_out_q <= io_out_d;
    end
  end

  assign io_out = io_out_q;
`else
  always_comb begin
    dmem_we_c   = D_wr;
    mem_rdata_c = D_rd ? dmem_q[D_addr] : '0;
  end
`endif

  // Data memory is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (dmem_we_c) begin
      dmem_q[D_addr] <= dmem_d;
    end
  end

  assign RF_Rp_zero = RF_Rp_rd && (rp_data_c == '0);

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath; registers are observed through RF_Rp_zero bit probes.
// Define DP_IO_PORT_EN to also exercise the memory-mapped I/O byte.
module tb_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D_addr;
  logic       D_rd, D_wr;
  logic [7:0] RF_W_data;
  logic       RF_s1, RF_s0;
  logic [3:0] RF_W_addr;
  logic       RF_W_wr;
  logic [3:0] RF_Rp_addr;
  logic       RF_Rp_rd;
  logic [3:0] RF_Rq_addr;
  logic       RF_Rq_rd;
  logic       alu_s1, alu_s0;
  logic       RF_Rp_zero;
`ifdef DP_IO_PORT_EN
  logic [7:0] io_in;
  logic [7:0] io_out;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] m_rf [16];
  logic [7:0] m_mem [int];

  always #5 clk = ~clk;

  datapath dut (
    .clk        (clk),
    .rst        (rst),
    .D_addr     (D_addr),
    .D_rd       (D_rd),
    .D_wr       (D_wr),
    .RF_W_data  (RF_W_data),
    .RF_s1      (RF_s1),
    .RF_s0      (RF_s0),
    .RF_W_addr  (RF_W_addr),
    .RF_W_wr    (RF_W_wr),
    .RF_Rp_addr (RF_Rp_addr),
    .RF_Rp_rd   (RF_Rp_rd),
    .RF_Rq_addr (RF_Rq_addr),
    .RF_Rq_rd   (RF_Rq_rd),
    .alu_s1     (alu_s1),
    .alu_s0     (alu_s0),
    .RF_Rp_zero (RF_Rp_zero)
`ifdef DP_IO_PORT_EN
    ,
    .io_in      (io_in),
    .io_out     (io_out)
`endif
  );

  function automatic logic [7:0] model_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a;
      1:       r = (a + b) % 256;
      2:       r = (a - b + 256) % 256;
      default: r = a & b;
    endcase
    return 8'(r);
  endfunction

  task automatic idle();
    D_rd = 1'b0; D_wr = 1'b0; RF_W_wr = 1'b0;
    RF_Rp_rd = 1'b0; RF_Rq_rd = 1'b0;
    RF_s1 = 1'b0; RF_s0 = 1'b0; alu_s1 = 1'b0; alu_s0 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
  endtask

  task automatic wr_imm(input int a, input int v);
    idle();
    RF_W_addr = 4'(a); RF_W_data = 8'(v);
    {RF_s1, RF_s0} = 2'b10; RF_W_wr = 1'b1;
    tick();
    m_rf[a] = 8'(v);
    idle();
  endtask

  task automatic alu_wr(input int p, input int q, input int op, input int w);
    logic [7:0] r;
    idle();
    RF_Rp_addr = 4'(p); RF_Rp_rd = 1'b1;
    RF_Rq_addr = 4'(q); RF_Rq_rd = 1'b1;
    {alu_s1, alu_s0} = 2'(op); {RF_s1, RF_s0} = 2'b00;
    RF_W_addr = 4'(w); RF_W_wr = 1'b1;
    r = model_alu(op, int'(m_rf[p]), int'(m_rf[q]));
    tick();
    m_rf[w] = r;
    idle();
  endtask

  // Store register p (or 0 when p_en=0) to address a.
  task automatic store(input int p, input bit p_en, input int a);
    idle();
    RF_Rp_addr = 4'(p); RF_Rp_rd = p_en;
    D_addr = 8'(a); D_wr = 1'b1;
    tick();
`ifdef DP_IO_PORT_EN
    if (a != 255) m_mem[a] = p_en ? m_rf[p] : 8'h00;
`else
    m_mem[a] = p_en ? m_rf[p] : 8'h00;
`endif
    idle();
  endtask

  task automatic load(input int a, input int w);
    idle();
    D_addr = 8'(a); D_rd = 1'b1;
    {RF_s1, RF_s0} = 2'b01; RF_W_addr = 4'(w); RF_W_wr = 1'b1;
    tick();
    m_rf[w] = m_mem[a];
    idle();
  endtask

  // Recover a register's value bit by bit (R14 = mask, R15 = masked result).
  task automatic probe(input int a, output logic [7:0] v);
    for (int b = 0; b < 8; b++) begin
      wr_imm(14, 1 << b);
      alu_wr(a, 14, 3, 15);
      RF_Rp_addr = 4'd15; RF_Rp_rd = 1'b1;
      #1;
      v[b] = ~RF_Rp_zero;
      RF_Rp_rd = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    idle();
    D_addr = 8'h00; RF_W_data = 8'h00; RF_W_addr = 4'd0;
    RF_Rp_addr = 4'd3; RF_Rq_addr = 4'd0;
`ifdef DP_IO_PORT_EN
    io_in = 8'h00;
`endif
    repeat (2) tick();
    tests++;
    if (RF_Rp_zero !== 1'b0) begin
      fails++; $display("FAIL reset_zero_out: got %b want 0", RF_Rp_zero);
    end
`ifdef DP_IO_PORT_EN
    tests++;
    if (io_out !== 8'h00) begin
      fails++; $display("FAIL reset_io_out: got %h want 00", io_out);
    end
`endif
    rst = 1'b0;
    model_reset();
    tick();
    RF_Rp_addr = 4'd0; RF_Rp_rd = 1'b1; #1;
    tests++;
    if (RF_Rp_zero !== 1'b1) begin
      fails++; $display("FAIL reset_r0_zero: got %b want 1", RF_Rp_zero);
    end
    wr_imm(3, 8'h55);
    RF_Rp_addr = 4'd3; RF_Rp_rd = 1'b1; #1;
    tests++;
    if (RF_Rp_zero !== 1'b0) begin
      fails++; $display("FAIL r3_written: zero got %b want 0", RF_Rp_zero);
    end
    // Mid-cycle async reset with a write pending across an edge.
    RF_W_addr = 4'd3; RF_W_data = 8'h77; {RF_s1, RF_s0} = 2'b10; RF_W_wr = 1'b1;
    rst = 1'b1; #1;
    model_reset();
    tests++;
    if (RF_Rp_zero !== 1'b1) begin
      fails++; $display("FAIL async_reset_immediate: zero got %b want 1", RF_Rp_zero);
    end
    tick();
    RF_W_wr = 1'b0; #1;
    rst = 1'b0; #1;
    tests++;
    if (RF_Rp_zero !== 1'b1) begin
      fails++; $display("FAIL reset_drops_write: zero got %b want 1", RF_Rp_zero);
    end
    idle();
    probe(3, v);
    tests++;
    if (v !== 8'h00) begin
      fails++; $display("FAIL reset_r3_value: got %h want 00", v);
    end
  endtask

  task automatic test_alu_directed();
    logic [7:0] v;
    logic [7:0] want [4];
    want[0] = 8'h0A; want[1] = 8'h03; want[2] = 8'h11; want[3] = 8'h08;
    wr_imm(1, 8'h0A);
    wr_imm(2, 8'hF9);
    for (int op = 0; op < 4; op++) begin
      alu_wr(1, 2, op, 4);
      probe(4, v);
      tests++;
      if (v !== want[op] || v !== m_rf[4]) begin
        fails++; $display("FAIL alu_op%0d: got %h want %h", op, v, want[op]);
      end
    end
  endtask

  task automatic test_alu_random();
    logic [7:0] v;
    int p, q, w, op;
    for (int it = 0; it < 12; it++) begin
      p = $urandom_range(0, 13);
      q = $urandom_range(0, 13);
      w = $urandom_range(0, 13);
      op = $urandom_range(0, 3);
      wr_imm(p, $urandom_range(0, 255));
      if (q != p) wr_imm(q, $urandom_range(0, 255));
      alu_wr(p, q, op, w);
      probe(w, v);
      tests++;
      if (v !== m_rf[w]) begin
        fails++; $display("FAIL alu_rand it%0d op%0d: got %h want %h", it, op, v, m_rf[w]);
      end
    end
  endtask

  task automatic test_wb_sel();
    logic [7:0] v;
    wr_imm(10, 8'h5A);
    idle();
    RF_W_addr = 4'd10; RF_W_data = 8'hEE; {RF_s1, RF_s0} = 2'b11; RF_W_wr = 1'b1;
    tick();
    m_rf[10] = 8'h00;
    idle();
    probe(10, v);
    tests++;
    if (v !== 8'h00) begin
      fails++; $display("FAIL wb_zero: got %h want 00", v);
    end
    wr_imm(11, 8'h66);
    idle();
    D_addr = 8'h20; D_rd = 1'b0; {RF_s1, RF_s0} = 2'b01;
    RF_W_addr = 4'd11; RF_W_wr = 1'b1;
    tick();
    m_rf[11] = 8'h00;
    idle();
    probe(11, v);
    tests++;
    if (v !== 8'h00) begin
      fails++; $display("FAIL load_rd_off: got %h want 00", v);
    end
  endtask

  task automatic test_mem();
    logic [7:0] v;
    int a, r, w;
    wr_imm(1, 8'h0A);
    wr_imm(2, 8'hF9);
    store(1, 1'b1, 8'h20);
    load(8'h20, 7);
    probe(7, v);
    tests++;
    if (v !== 8'h0A) begin
      fails++; $display("FAIL store_load: got %h want 0A", v);
    end
    // Simultaneous read and write: read sees pre-write contents.
    idle();
    RF_Rp_addr = 4'd2; RF_Rp_rd = 1'b1;
    D_addr = 8'h20; D_rd = 1'b1; D_wr = 1'b1;
    {RF_s1, RF_s0} = 2'b01; RF_W_addr = 4'd8; RF_W_wr = 1'b1;
    tick();
    m_rf[8] = m_mem[8'h20];
    m_mem[8'h20] = m_rf[2];
    idle();
    probe(8, v);
    tests++;
    if (v !== 8'h0A) begin
      fails++; $display("FAIL rd_wr_same_old: got %h want 0A", v);
    end
    load(8'h20, 9);
    probe(9, v);
    tests++;
    if (v !== 8'hF9) begin
      fails++; $display("FAIL rd_wr_same_new: got %h want F9", v);
    end
    store(2, 1'b0, 8'h21);
    wr_imm(9, 8'h44);
    load(8'h21, 9);
    probe(9, v);
    tests++;
    if (v !== 8'h00) begin
      fails++; $display("FAIL store_rp_off: got %h want 00", v);
    end
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, 254);
      r = $urandom_range(0, 13);
      w = $urandom_range(0, 13);
      wr_imm(r, $urandom_range(0, 255));
      store(r, 1'b1, a);
      load(a, w);
      probe(w, v);
      tests++;
      if (v !== m_rf[w]) begin
        fails++; $display("FAIL mem_rand it%0d addr %h: got %h want %h", it, a, v, m_rf[w]);
      end
    end
    // Memory contents survive a reset.
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    load(8'h20, 12);
    probe(12, v);
    tests++;
    if (v !== 8'hF9) begin
      fails++; $display("FAIL mem_persist_reset: got %h want F9", v);
    end
  endtask

  task automatic test_read_during_write();
    wr_imm(5, 8'h00);
    idle();
    RF_W_addr = 4'd5; RF_W_data = 8'h33; {RF_s1, RF_s0} = 2'b10; RF_W_wr = 1'b1;
    RF_Rp_addr = 4'd5; RF_Rp_rd = 1'b1;
    #1;
    tests++;
    if (RF_Rp_zero !== 1'b1) begin
      fails++; $display("FAIL rdw_old: zero got %b want 1", RF_Rp_zero);
    end
    tick();
    m_rf[5] = 8'h33;
    RF_W_wr = 1'b0; #1;
    tests++;
    if (RF_Rp_zero !== 1'b0) begin
      fails++; $display("FAIL rdw_new: zero got %b want 0", RF_Rp_zero);
    end
    wr_imm(0, 8'h00);
    RF_Rp_addr = 4'd0; RF_Rp_rd = 1'b0; #1;
    tests++;
    if (RF_Rp_zero !== 1'b0) begin
      fails++; $display("FAIL rp_rd_off: zero got %b want 0", RF_Rp_zero);
    end
  endtask

`ifdef DP_IO_PORT_EN
  task automatic test_io();
    logic [7:0] v;
    wr_imm(1, 8'h0A);
    store(1, 1'b1, 8'hFF);
    tests++;
    if (io_out !== 8'h0A) begin
      fails++; $display("FAIL io_out_store: got %h want 0A", io_out);
    end
    io_in = 8'hC3;
    load(8'hFF, 6);
    m_rf[6] = 8'hC3;
    probe(6, v);
    tests++;
    if (v !== 8'hC3) begin
      fails++; $display("FAIL io_in_load: got %h want C3", v);
    end
    wr_imm(2, 8'h9B);
    store(2, 1'b1, 8'hFE);
    load(8'hFE, 6);
    probe(6, v);
    tests++;
    if (v !== 8'h9B || io_out !== 8'h0A) begin
      fails++; $display("FAIL io_neighbour: got %h io %h want 9B io 0A", v, io_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_wb_sel();
    test_mem();
    test_read_during_write();
`ifdef DP_IO_PORT_EN
    test_io();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
